int_to_float: RTL
=================

Name: int_to_float

Overview:
Converts a 32-bit two's-complement signed integer to an IEEE-754 single-precision value with round-to-nearest-even. It sits directly upstream of the GMM floating-point multiplier. It turns integer pixel intensities and fixed integer coefficients into the float operands the multiplier consumes. It uses the same stb/ack word handshake on both sides, so its output_z/output_z_stb/output_z_ack connect straight to a multiplier input port.

Parameters:
none (fixed at 32-bit integer in, binary32 out)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low (rst = 0 resets)
input_a  input  32  signed integer operand
input_a_stb  input  1  upstream asserts when input_a is valid
input_a_ack  output  1  high while the block can accept an operand
output_z  output  32  binary32 result
output_z_stb  output  1  output_z valid
output_z_ack  input  1  downstream has taken output_z

Behaviour:
- Reset (rst low, asynchronous): state <= get_a, input_a_ack = 0, output_z_stb = 0, output_z = 0. Takes effect mid-conversion too; the in-flight operand is discarded and no partial result is emitted.
- Handshake:
  - A transfer occurs on a rising edge where input_a_ack and input_a_stb are both high.
  - In get_a, input_a_ack is driven to 1, so it rises on the first edge after reset release or after returning to get_a.
  - On transfer, input_a is captured and input_a_ack drops on that same edge.
  - In put_z, output_z_stb and output_z are held stable until an edge sees output_z_stb && output_z_ack. On that edge, output_z_stb drops and state returns to get_a.
  - No pipelining: one operand in flight.
- States and transitions:
  - get_a: wait for transfer -> convert_0.
  - convert_0:
    - If a == 0: z <= 0x00000000, -> put_z.
    - Otherwise: s <= a[31]; v <= |a| as 32-bit unsigned (0x80000000 stays 0x80000000); e <= 31; -> normalise.
  - normalise: if v[31] == 0 then v <<= 1 and e -= 1, stay; else -> extract. Takes lz+1 cycles, where lz = leading zeros of |a| (0..31).
  - extract: m <= v[31:8] (24 bits), guard <= v[7], round_bit <= v[6], sticky <= |v[5:0]; -> round.
  - round:
    - If guard && (round_bit | sticky | m[0]), then m <= m + 1.
    - If m == 24'hFFFFFF, m wraps to 0 and e <= e + 1.
    - -> pack.
  - pack: z[31] = s, z[30:23] = e + 127, z[22:0] = m[22:0]; -> put_z.
  - put_z: as handshake above.
- Width rules:
  - e is held in 6 bits unsigned (range 0..32); the exponent field is e + 127, in range 127..159. Overflow, NaN, inf and denormal cannot occur.
  - Results are exact when |a| < 2^24.
- Latency, counted from the accepting edge (edge 0):
  - Nonzero input: output_z_stb high after edge 6 + lz.
  - Zero input: output_z_stb high after edge 2.
  - Minimum 6, maximum 37.
- Throughput: next input_a_ack rises one edge after output is taken.
- Simultaneous events:
  - input_a_stb held high while busy is ignored.
  - output_z_ack held high before output_z_stb rises has no effect until put_z, then completes the transfer on that first edge.

Decomposition:
- Shared float package holds:
  - state encodings (get_a, convert_0, normalise, extract, round, pack, put_z, 3 bits);
  - EXP_BIAS = 127;
  - binary32 field positions (sign 31, exponent 30:23, mantissa 22:0);
  - constant FLOAT_ZERO.
- These are shared with the multiplier and the planned adder.
- No sub-module needed; single FSM module.

Test Plan:
- 1 -> 0x3F800000, stb after edge 37; -1 -> 0xBF800000.
- 0 -> 0x00000000 after edge 2; back-to-back with 5 -> 0x40A00000; input_a_ack re-rises one edge after each output transfer.
- Rounding:
  - 0x7FFFFFFF -> 0x4F000000 (round carry bumps exponent);
  - 0x80000000 -> 0xCF000000;
  - 16777217 -> 0x4B800000 (tie to even, down);
  - 16777219 -> 0x4B800002 (tie, up).
- Backpressure: 1000 -> 0x447A0000 with output_z_ack low 10 cycles -> output_z_stb and output_z stable throughout; input_a_stb asserted meanwhile is not acked.
- Reset mid-normalise of input 3: pull rst low 2 cycles -> input_a_ack = 0, output_z_stb = 0, output_z = 0 immediately. After release, 7 -> 0x40E00000, and no stale result for 3 appears.
- Random regression: 10k random signed ints vs reference real-to-float model, bit-exact.

Source files
------------

// File: rtl/int_to_float_pkg.sv
// Shared binary32 definitions for the float datapath blocks (converter, multiplier, adder).
package int_to_float_pkg;

    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        CONVERT_0 = 3'd1,
        NORMALISE = 3'd2,
        EXTRACT   = 3'd3,
        ROUND     = 3'd4,
        PACK      = 3'd5,
        PUT_Z     = 3'd6
    } fsm_state_e;

    localparam logic [7:0]  EXP_BIAS   = 8'd127;
    localparam int          SIGN_BIT   = 31;
    localparam int          EXP_MSB    = 30;
    localparam int          EXP_LSB    = 23;
    localparam int          MAN_MSB    = 22;
    localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/int_to_float.sv
// Signed 32-bit integer to binary32 converter, round-to-nearest-even, stb/ack on both sides.
//  state     | meaning
//  GET_A     | ready for an operand, input_a_ack high
//  CONVERT_0 | zero shortcut, or split into sign and magnitude
//  NORMALISE | shift left one bit per cycle until the MSB is set
//  EXTRACT   | take 24-bit mantissa plus guard/round/sticky
//  ROUND     | round to nearest even, carry bumps the exponent
//  PACK      | assemble sign/exponent/mantissa
//  PUT_Z     | present result until downstream acks
module int_to_float
    import int_to_float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    fsm_state_e  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] v_q, v_d;
    logic [5:0]  e_q, e_d;
    logic [23:0] m_q, m_d;
    logic        s_q, s_d;
    logic        guard_q, guard_d;
    logic        round_q, round_d;
    logic        sticky_q, sticky_d;
    logic [31:0] z_q, z_d;
    logic        ack_q, ack_d;
    logic        stb_q, stb_d;
    logic [31:0] out_q, out_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            v_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            s_q      <= 1'b0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= FLOAT_ZERO;
            ack_q    <= 1'b0;
            stb_q    <= 1'b0;
            out_q    <= FLOAT_ZERO;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            v_q      <= v_d;
            e_q      <= e_d;
            m_q      <= m_d;
            s_q      <= s_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        v_d      = v_q;
        e_d      = e_q;
        m_d      = m_q;
        s_d      = s_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        z_d      = z_q;
        ack_d    = ack_q;
        stb_d    = stb_q;
        out_d    = out_q;

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (ack_q && input_a_stb) begin
                    a_d     = input_a;
                    ack_d   = 1'b0;
                    state_d = CONVERT_0;
                end
            end
            CONVERT_0: begin
                if (a_q == 32'd0) begin
                    z_d     = FLOAT_ZERO;
                    state_d = PUT_Z;
                end else begin
                    // 0x80000000 negates to itself, which is the correct unsigned magnitude
                    s_d     = a_q[31];
                    v_d     = a_q[31] ? (~a_q + 32'd1) : a_q;
                    e_d     = 6'd31;
                    state_d = NORMALISE;
                end
            end
            NORMALISE: begin
                if (!v_q[31]) begin
                    v_d = v_q << 1;
                    e_d = e_q - 6'd1;
                end else begin
                    state_d = EXTRACT;
                end
            end
            EXTRACT: begin
                m_d      = v_q[31:8];
                guard_d  = v_q[7];
                round_d  = v_q[6];
                sticky_d = |v_q[5:0];
                state_d  = ROUND;
            end
            ROUND: begin
                if (guard_q && (round_q || sticky_q || m_q[0])) begin
                    m_d = m_q + 24'd1;
                    if (m_q == 24'hFF_FFFF) begin
                        e_d = e_q + 6'd1;
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                z_d[SIGN_BIT]        = s_q;
                z_d[EXP_MSB:EXP_LSB] = {2'b00, e_q} + EXP_BIAS;
                z_d[MAN_MSB:0]       = m_q[MAN_MSB:0];
                state_d              = PUT_Z;
            end
            PUT_Z: begin
                stb_d = 1'b1;
                out_d = z_q;
                if (stb_q && output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = out_q;

endmodule
